sym_pair_sum_buf: RTL and testbench
===================================

Name: sym_pair_sum_buf

Overview:
Parametrised symmetric-FIR sample buffer with a built-in tap-pair sequencer, for halfband and general odd-length symmetric filters in the sdr_lib DSP chain. Each accepted input sample is written into a circular RAM. The block then walks all symmetric tap pairs, emitting one pre-added, halved and rounded pair sum per cycle, followed by the centre sample. A downstream single-multiplier MAC consumes the stream.

Parameters:
WIDTH, 16, signed sample and output width
ADDR_BITS, 5, RAM depth = 2**ADDR_BITS
NTAPS, 31, filter length; must be odd, 3 <= NTAPS <= 2**ADDR_BITS; NPAIRS = (NTAPS-1)/2
ROUND_MODE, 1, halving mode: 0 floor, 1 round toward zero, 2 convergent (round half to even)

Ports:
clock  in  1  sole clock
reset_n  in  1  synchronous, active-low reset
in_stb  in  1  input sample strobe
in_data  in  WIDTH  signed input sample
in_ready  out  1  high when a sample can be accepted
sum_stb  out  1  sum/centre output valid
sum  out  WIDTH  halved pair sum, or centre sample
sum_first  out  1  marks pair k=0 (valid with sum_stb)
sum_last  out  1  marks centre sample (valid with sum_stb)
primed  out  1  NTAPS samples have been written since reset
overrun  out  1  sticky: in_stb was seen while in_ready=0

Behaviour:
- Reset: one clock and one reset_n. Reset is synchronous and active-low.
  - While reset_n=0, all of the following are cleared: wr_ptr=0, fill count=0, state=IDLE, k=0.
  - Outputs during reset: in_ready=0, sum_stb=0, sum=0, sum_first=0, sum_last=0, primed=0, overrun=0.
  - RAM contents are not cleared.
  - in_ready rises the first cycle after reset_n returns high.
- Accept: an input is accepted when in_stb=1 and in_ready=1 at cycle T.
  - in_data is written to RAM[wr_ptr]; wr_ptr increments modulo 2**ADDR_BITS.
  - The fill count increments, saturating at NTAPS.
- in_stb while in_ready=0: the sample is dropped, nothing is written, and overrun is set (sticky until reset).
- FSM IDLE (in_ready=1):
  - On accept with the post-write fill count = NTAPS, go to RUN with k=0.
  - Otherwise stay in IDLE; no outputs are produced while unprimed.
- FSM RUN (in_ready=0), one address pair per cycle, with n = index of the newest sample:
  - For k < NPAIRS: read RAM[n-k] and RAM[n-(NTAPS-1-k)], indices modulo depth.
  - For k = NPAIRS: read RAM[n-NPAIRS] alone (centre).
  - After k = NPAIRS, return to IDLE.
  - RUN occupies T+1 .. T+1+NPAIRS. The next accept is possible at T+2+NPAIRS, giving a throughput of 1 sample per NPAIRS+2 cycles.
- Read path:
  - RAM reads are asynchronous; the output register gives 1 cycle of latency.
  - Pair k appears on sum at T+2+k with sum_stb=1. sum_first=1 at k=0; sum_last=1 on the centre word only.
  - A write in cycle T is visible to reads in T+1 (no bypass needed).
- Arithmetic:
  - s = sign-extended a + b, WIDTH+1 bits.
  - Mode 0: sum = s[W:1].
  - Mode 1: sum = s[W:1] + (s[W] & s[0]).
  - Mode 2: sum = s[W:1] + (s[0] & s[1]).
  - No overflow is possible in any mode; no saturation logic.
- Centre word: the raw sample, unmodified.
- Reset mid-RUN: the sequence aborts immediately and no further sum_stb is issued.
- Outputs are held at their last value when sum_stb=0; only sum_stb, sum_first and sum_last return to 0.

Decomposition:
- Package sym_fir_pkg:
  - ROUND_FLOOR=0, ROUND_ZERO=1, ROUND_CONV=2.
  - FSM state encoding (IDLE, RUN).
  - Helper constant function for NPAIRS.
- Sub-module sym_round: combinational halving/rounding of a WIDTH+1 sum, parametrised by WIDTH and ROUND_MODE.
  - The centre path bypasses it.

Test Plan:
- Priming (WIDTH=16, NTAPS=5, ADDR_BITS=5, mode 1): write 1,2,3,4 → no sum_stb, primed=0. Write 5 → sum = 3 (first), 3, 3 (last) on consecutive cycles T+2..T+4; primed=1.
- Rounding (NTAPS=3): pair -3 with 0 → mode 0 gives -2, mode 1 gives -1, mode 2 gives -2. Pair 3 with 0 → mode 0 gives 1, mode 1 gives 1, mode 2 gives 2. Extremes: 32767 with 32767 → 32767; -32768 with -32768 → -32768.
- Wrap-around (ADDR_BITS=3, NTAPS=5): stream ramp 1..20 at max rate → every group matches the reference model across pointer wrap; overrun stays 0.
- Overrun: in_stb asserted during RUN (cycle T+1) → sample not written, group output unchanged, overrun=1 and remains 1.
- Reset mid-RUN: drop reset_n at T+2 → sum_stb=0 and all outputs 0 next cycle. After release, primed=0 and NTAPS new samples are required before output.
- Throughput (NTAPS=31): back-to-back in_stb → accepts exactly every 17 cycles. Each group has 16 sum_stb with exactly one sum_first and one sum_last.

Source files
------------

// File: rtl/sym_pair_sum_buf_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sym_fir_pkg
//  Purpose  : Shared constants, FSM state encoding and helpers for the
//             symmetric-FIR pair-sum buffer.
//  Contents : ROUND_* halving-mode selectors, state_t, npairs()
//  Revision : 1.0  initial release
// ============================================================================
package sym_fir_pkg;

    // Halving mode selectors for the pair-sum path
    localparam int ROUND_FLOOR = 0;   // arithmetic shift, rounds toward -inf
    localparam int ROUND_ZERO  = 1;   // rounds toward zero
    localparam int ROUND_CONV  = 2;   // round half to even

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Number of symmetric tap pairs in an odd-length filter
    function automatic int npairs(input int ntaps);
        return (ntaps - 1) / 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sym_pair_sum_buf_round.sv
`default_nettype none
// ============================================================================
//  Module   : sym_round
//  Purpose  : Combinational halving of a WIDTH+1-bit signed pair sum back to
//             WIDTH bits with a selectable rounding rule.
//  Ports    : i_sum  [WIDTH:0]   signed a+b
//             o_half [WIDTH-1:0] halved and rounded result
//  Revision : 1.0  initial release
// ============================================================================
module sym_round #(
    parameter int WIDTH      = 16,
    parameter int ROUND_MODE = 1
) (
    input  logic signed [WIDTH:0]   i_sum,
    output logic signed [WIDTH-1:0] o_half
);
    import sym_fir_pkg::*;

    logic [WIDTH-1:0] w_trunc;
    logic             w_inc;

    // Dropping the LSB is a floor division by two
    assign w_trunc = i_sum[WIDTH:1];

    generate
        if (ROUND_MODE == ROUND_FLOOR) begin : g_floor
            // LSB referenced only to keep the full input in use
            assign w_inc = i_sum[0] & 1'b0;
        end else if (ROUND_MODE == ROUND_ZERO) begin : g_zero
            // Negative odd sums were floored one step too far
            assign w_inc = i_sum[WIDTH] & i_sum[0];
        end else begin : g_conv
            // Exact half with odd floor result: step up to the even neighbour
            assign w_inc = i_sum[0] & i_sum[1];
        end
    endgenerate

    // The increment can never overflow: it only fires when the floor result
    // is strictly below the representable maximum.
    assign o_half = w_trunc + {{(WIDTH-1){1'b0}}, w_inc};

endmodule
`default_nettype wire

// File: rtl/sym_pair_sum_buf.sv
`default_nettype none
// ============================================================================
//  Module   : sym_pair_sum_buf
//  Purpose  : Circular sample buffer for odd-length symmetric FIR filters.
//             Every accepted sample (once NTAPS are held) launches a walk
//             over all tap pairs, emitting one halved pair sum per cycle and
//             finally the raw centre sample, for a single-multiplier MAC.
//  Ports    : clock, reset_n (sync, active-low)
//             in_stb/in_data/in_ready   sample input handshake
//             sum_stb/sum/sum_first/sum_last   pair-sum stream
//             primed   NTAPS samples written since reset
//             overrun  sticky: strobe seen while not ready
//  Revision : 1.0  initial release
// ============================================================================
module sym_pair_sum_buf
    import sym_fir_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int ADDR_BITS  = 5,
    parameter int NTAPS      = 31,
    parameter int ROUND_MODE = 1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    in_stb,
    input  logic signed [WIDTH-1:0] in_data,
    output logic                    in_ready,
    output logic                    sum_stb,
    output logic signed [WIDTH-1:0] sum,
    output logic                    sum_first,
    output logic                    sum_last,
    output logic                    primed,
    output logic                    overrun
);

    localparam int c_depth  = 2 ** ADDR_BITS;
    localparam int c_npairs = npairs(NTAPS);
    localparam int c_kw     = $clog2(c_npairs + 1);
    localparam int c_fw     = $clog2(NTAPS + 1);

    localparam logic [c_kw-1:0]      c_k_last    = c_kw'(c_npairs);
    localparam logic [c_fw-1:0]      c_fill_full = c_fw'(NTAPS);
    localparam logic [ADDR_BITS-1:0] c_tail      = ADDR_BITS'(NTAPS - 1);

    logic [WIDTH-1:0]     r_ram [0:c_depth-1];
    logic [ADDR_BITS-1:0] r_wr_ptr;
    logic [c_fw-1:0]      r_fill;
    state_t               r_state;
    logic [c_kw-1:0]      r_k;
    logic                 r_alive;
    logic                 r_overrun;
    logic                 r_sum_stb;
    logic [WIDTH-1:0]     r_sum;
    logic                 r_sum_first;
    logic                 r_sum_last;

    state_t               w_state_nxt;
    logic [c_kw-1:0]      w_k_nxt;
    logic                 w_emit;
    logic                 w_accept;
    logic [c_fw-1:0]      w_fill_inc;
    logic [ADDR_BITS-1:0] w_newest;
    logic [ADDR_BITS-1:0] w_addr_a;
    logic [ADDR_BITS-1:0] w_addr_b;
    logic [WIDTH-1:0]     w_a;
    logic [WIDTH-1:0]     w_b;
    logic signed [WIDTH:0]   w_pair;
    logic signed [WIDTH-1:0] w_half;

    // r_alive keeps in_ready low for the whole reset and releases it one
    // cycle after reset_n is sampled high.
    assign in_ready = r_alive & (r_state == ST_IDLE);
    assign w_accept = reset_n & in_stb & in_ready;
    assign w_fill_inc = (r_fill == c_fill_full) ? r_fill : r_fill + 1'b1;

    // ------------------------------------------------------------------
    // Sequencer: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_k     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_emit      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && (w_fill_inc == c_fill_full)) begin
                    w_state_nxt = ST_RUN;
                    w_k_nxt     = '0;
                end
            end
            ST_RUN: begin
                w_emit = 1'b1;
                if (r_k == c_k_last) begin
                    w_state_nxt = ST_IDLE;
                    w_k_nxt     = '0;
                end else begin
                    w_k_nxt = r_k + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_k_nxt     = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sample RAM: never reset, asynchronous read
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_ram[r_wr_ptr] <= in_data;
        end
    end

    // The pointer has already advanced past the newest sample while RUN is
    // active; modulo-depth wrap falls out of the ADDR_BITS arithmetic.
    assign w_newest = r_wr_ptr - 1'b1;
    assign w_addr_a = w_newest - ADDR_BITS'(r_k);
    assign w_addr_b = w_newest - c_tail + ADDR_BITS'(r_k);
    assign w_a      = r_ram[w_addr_a];
    assign w_b      = r_ram[w_addr_b];
    assign w_pair   = {w_a[WIDTH-1], w_a} + {w_b[WIDTH-1], w_b};

    sym_round #(
        .WIDTH      (WIDTH),
        .ROUND_MODE (ROUND_MODE)
    ) u_round (
        .i_sum  (w_pair),
        .o_half (w_half)
    );

    // ------------------------------------------------------------------
    // Write side bookkeeping and output register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_wr_ptr    <= '0;
            r_fill      <= '0;
            r_alive     <= 1'b0;
            r_overrun   <= 1'b0;
            r_sum_stb   <= 1'b0;
            r_sum       <= '0;
            r_sum_first <= 1'b0;
            r_sum_last  <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_fill   <= w_fill_inc;
            end
            if (in_stb && !in_ready) begin
                r_overrun <= 1'b1;
            end
            r_sum_stb   <= w_emit;
            r_sum_first <= w_emit && (r_k == '0);
            r_sum_last  <= w_emit && (r_k == c_k_last);
            // Centre word is passed through raw; pair words are halved
            if (w_emit) begin
                r_sum <= (r_k == c_k_last) ? w_a : w_half;
            end
        end
    end

    assign sum_stb   = r_sum_stb;
    assign sum       = r_sum;
    assign sum_first = r_sum_first;
    assign sum_last  = r_sum_last;
    assign primed    = (r_fill == c_fill_full);
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sym_pair_sum_buf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sym_pair_sum_buf
//  Purpose  : Self-checking bench for sym_pair_sum_buf. Instance A (NTAPS=5,
//             depth 8, round-to-zero) is tracked every cycle by a sample
//             history model; three NTAPS=3 instances exercise the rounding
//             modes; an NTAPS=31 instance exercises throughput.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sym_pair_sum_buf;

    localparam int NT = 5;
    localparam int NP = (NT - 1) / 2;
    localparam int A_MODE = 1;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- instance A ----------------
    logic               a_stb = 1'b0;
    logic signed [15:0] a_data = '0;
    logic               a_ready, a_sum_stb, a_first, a_last, a_primed, a_ovr;
    logic signed [15:0] a_sum;

    sym_pair_sum_buf #(.WIDTH(16), .ADDR_BITS(3), .NTAPS(NT), .ROUND_MODE(A_MODE)) u_dut_a (
        .clock(clock), .reset_n(reset_n), .in_stb(a_stb), .in_data(a_data),
        .in_ready(a_ready), .sum_stb(a_sum_stb), .sum(a_sum), .sum_first(a_first),
        .sum_last(a_last), .primed(a_primed), .overrun(a_ovr));

    // ---------------- rounding instances ----------------
    logic               r_stb = 1'b0;
    logic signed [15:0] r_data = '0;
    logic               rr_ready [3];
    logic               rr_stb_o [3];
    logic               rr_first [3];
    logic               rr_last  [3];
    logic               rr_primed[3];
    logic               rr_ovr   [3];
    logic signed [15:0] rr_sum   [3];

    for (genvar g = 0; g < 3; g++) begin : g_rnd
        sym_pair_sum_buf #(.WIDTH(16), .ADDR_BITS(5), .NTAPS(3), .ROUND_MODE(g)) u_dut_r (
            .clock(clock), .reset_n(reset_n), .in_stb(r_stb), .in_data(r_data),
            .in_ready(rr_ready[g]), .sum_stb(rr_stb_o[g]), .sum(rr_sum[g]),
            .sum_first(rr_first[g]), .sum_last(rr_last[g]), .primed(rr_primed[g]),
            .overrun(rr_ovr[g]));
    end

    // ---------------- throughput instance ----------------
    logic               t_stb = 1'b0;
    logic signed [15:0] t_data = '0;
    logic               t_ready, t_sum_stb, t_first, t_last, t_primed, t_ovr;
    logic signed [15:0] t_sum;

    sym_pair_sum_buf #(.WIDTH(16), .ADDR_BITS(5), .NTAPS(31), .ROUND_MODE(2)) u_dut_t (
        .clock(clock), .reset_n(reset_n), .in_stb(t_stb), .in_data(t_data),
        .in_ready(t_ready), .sum_stb(t_sum_stb), .sum(t_sum), .sum_first(t_first),
        .sum_last(t_last), .primed(t_primed), .overrun(t_ovr));

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_miss++;
        $display("FAIL %s: got timeout, expected handshake (cycle %0d)", name, cyc);
    endtask

    // Halving rule stated in plain integer arithmetic
    function automatic int halve(input int a, input int b, input int mode);
        int s, fl;
        s  = a + b;
        fl = (s >= 0) ? s / 2 : -((1 - s) / 2);
        if (mode == 0) return fl;
        if (mode == 1) return s / 2;
        if (s % 2 == 0) return s / 2;
        return (fl % 2 == 0) ? fl : fl + 1;
    endfunction

    // ---------------- model for instance A ----------------
    typedef struct {
        int due;
        int val;
        bit first;
        bit last;
    } exp_t;

    exp_t m_q[$];
    int   m_hist[$];
    int   m_fill = 0;
    bit   m_valid = 1'b0;
    bit   m_ready = 1'b0;
    bit   m_primed = 1'b0;
    bit   m_ovr = 1'b0;
    int   m_sum = 0;
    int   m_run_end = -1;
    int   a_log[$];

    always @(negedge clock) begin
        bit   stb_e;
        exp_t e;
        int   n;
        if (a_sum_stb === 1'b1) a_log.push_back(int'(a_sum));
        if (m_valid) begin
            stb_e = (m_q.size() > 0) && (m_q[0].due == cyc);
            chk("a_in_ready", a_ready, m_ready);
            chk("a_primed", a_primed, m_primed);
            chk("a_overrun", a_ovr, m_ovr);
            chk("a_sum_stb", a_sum_stb, stb_e);
            if (stb_e) begin
                e = m_q.pop_front();
                m_sum = e.val;
                chk("a_sum_first", a_first, e.first);
                chk("a_sum_last", a_last, e.last);
            end else begin
                chk("a_sum_first_idle", a_first, 0);
                chk("a_sum_last_idle", a_last, 0);
            end
            chk("a_sum", a_sum, m_sum);
        end
        // advance model to the next cycle
        if (!reset_n) begin
            m_valid = 1'b1;
            m_ready = 1'b0;
            m_primed = 1'b0;
            m_ovr = 1'b0;
            m_sum = 0;
            m_fill = 0;
            m_run_end = -1;
            m_q.delete();
            m_hist.delete();
        end else if (m_valid) begin
            if (a_stb && m_ready) begin
                m_hist.push_back(int'(a_data));
                if (m_fill < NT) m_fill++;
                if (m_fill == NT) begin
                    n = m_hist.size() - 1;
                    for (int k = 0; k < NP; k++)
                        m_q.push_back('{cyc + 2 + k,
                                        halve(m_hist[n - k], m_hist[n - (NT - 1 - k)], A_MODE),
                                        (k == 0), 1'b0});
                    m_q.push_back('{cyc + 2 + NP, m_hist[n - NP], 1'b0, 1'b1});
                    m_run_end = cyc + 1 + NP;
                end
            end else if (a_stb) begin
                m_ovr = 1'b1;
            end
            m_ready = (cyc + 1 > m_run_end);
            m_primed = (m_fill == NT);
        end
    end

    // ---------------- rounding capture ----------------
    int r_grp = 0;
    int rp[3];
    int r_ctr = 0;

    always @(negedge clock) begin
        if (rr_stb_o[0] === 1'b1 && rr_first[0] === 1'b1) begin
            for (int j = 0; j < 3; j++) rp[j] = int'(rr_sum[j]);
            r_grp++;
        end
        if (rr_stb_o[0] === 1'b1 && rr_last[0] === 1'b1) r_ctr = int'(rr_sum[2]);
    end

    // ---------------- stimulus tasks ----------------
    task automatic send_a(input int v);
        int w;
        w = 0;
        while (a_ready !== 1'b1 && w < 50) begin @(posedge clock); #1; w++; end
        if (a_ready !== 1'b1) timeout("a_ready_wait");
        a_stb = 1'b1;
        a_data = 16'(v);
        @(posedge clock); #1;
        a_stb = 1'b0;
    endtask

    task automatic send_r(input int v);
        int w;
        w = 0;
        while (rr_ready[0] !== 1'b1 && w < 50) begin @(posedge clock); #1; w++; end
        if (rr_ready[0] !== 1'b1) timeout("r_ready_wait");
        r_stb = 1'b1;
        r_data = 16'(v);
        @(posedge clock); #1;
        r_stb = 1'b0;
    endtask

    task automatic wait_rgrp(input int target);
        int w;
        w = 0;
        while (r_grp < target && w < 50) begin @(posedge clock); #1; w++; end
        if (r_grp < target) timeout("r_group_wait");
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        repeat (n) @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
    endtask

    // Rounding expectations, hand-computed per mode 0/1/2
    int rexp[4][3] = '{'{-2, -1, -2}, '{1, 1, 2}, '{32767, 32767, 32767},
                       '{-32768, -32768, -32768}};
    int rgrp_at[4] = '{1, 3, 6, 9};

    // ---------------- main sequence ----------------
    initial begin
        int trig_q[$];
        int acc_n, last_acc, cnt, nf, groups;
        bit acc;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_in_ready", a_ready, 0);
        chk("rst_sum_stb", a_sum_stb, 0);
        chk("rst_sum", a_sum, 0);
        chk("rst_primed", a_primed, 0);
        chk("rst_overrun", a_ovr, 0);
        reset_n = 1'b1;
        @(posedge clock); #1;
        chk("ready_after_reset", a_ready, 1);

        // Priming: 1..4 produce nothing, 5 gives 3,3,3
        a_log.delete();
        for (int i = 1; i <= 4; i++) send_a(i);
        repeat (3) @(posedge clock);
        #1;
        chk("prime_no_output", a_log.size(), 0);
        chk("prime_not_primed", a_primed, 0);
        send_a(5);
        repeat (5) @(posedge clock);
        #1;
        chk("prime_group_len", a_log.size(), 3);
        for (int i = 0; i < 3 && i < a_log.size(); i++) chk("prime_value", a_log[i], 3);
        chk("prime_primed", a_primed, 1);

        // Overrun: strobe during RUN
        send_a(6);
        a_stb = 1'b1;
        a_data = 16'sd99;
        @(posedge clock); #1;
        a_stb = 1'b0;
        chk("overrun_set", a_ovr, 1);
        repeat (4) @(posedge clock);
        #1;
        a_log.delete();
        send_a(7);
        repeat (5) @(posedge clock);
        #1;
        chk("overrun_sticky", a_ovr, 1);
        for (int i = 0; i < 3 && i < a_log.size(); i++) chk("after_overrun_value", a_log[i], 5);

        // Reset in the middle of a run
        send_a(8);
        @(posedge clock); #1;
        reset_n = 1'b0;
        @(posedge clock); #1;
        chk("midrst_sum_stb", a_sum_stb, 0);
        chk("midrst_sum", a_sum, 0);
        chk("midrst_last", a_last, 0);
        chk("midrst_overrun", a_ovr, 0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        chk("midrst_primed", a_primed, 0);
        a_log.delete();
        for (int i = 10; i <= 13; i++) send_a(i);
        repeat (3) @(posedge clock);
        #1;
        chk("reprime_no_output", a_log.size(), 0);
        send_a(14);
        repeat (5) @(posedge clock);
        #1;
        chk("reprime_group_len", a_log.size(), 3);
        for (int i = 0; i < 3 && i < a_log.size(); i++) chk("reprime_value", a_log[i], 12);

        // Wrap-around: ramp 1..20 at full rate through a depth-8 RAM
        do_reset(2);
        a_log.delete();
        for (int i = 1; i <= 20; i++) send_a(i);
        repeat (6) @(posedge clock);
        #1;
        chk("wrap_words", a_log.size(), 16 * 3);
        chk("wrap_no_overrun", a_ovr, 0);

        // Rounding modes, NTAPS=3
        do_reset(2);
        send_r(-3); send_r(7); send_r(0);
        wait_rgrp(rgrp_at[0]);
        for (int j = 0; j < 3; j++) chk($sformatf("round_neg3_mode%0d", j), rp[j], rexp[0][j]);
        chk("round_centre_raw", r_ctr, 7);
        send_r(5); send_r(3);
        wait_rgrp(rgrp_at[1]);
        for (int j = 0; j < 3; j++) chk($sformatf("round_pos3_mode%0d", j), rp[j], rexp[1][j]);
        for (int i = 0; i < 3; i++) send_r(32767);
        wait_rgrp(rgrp_at[2]);
        for (int j = 0; j < 3; j++) chk($sformatf("round_max_mode%0d", j), rp[j], rexp[2][j]);
        for (int i = 0; i < 3; i++) send_r(-32768);
        wait_rgrp(rgrp_at[3]);
        for (int j = 0; j < 3; j++) chk($sformatf("round_min_mode%0d", j), rp[j], rexp[3][j]);
        chk("round_centre_min", r_ctr, -32768);

        // Throughput, NTAPS=31, strobe held high
        do_reset(2);
        t_data = 16'sd1;
        t_stb = 1'b1;
        acc_n = 0; last_acc = -1; cnt = 0; nf = 0; groups = 0;
        for (int i = 0; i < 31 + 17 * 5 + 4; i++) begin
            @(negedge clock);
            acc = (t_ready === 1'b1);
            if (t_sum_stb === 1'b1) begin
                cnt++;
                if (t_first === 1'b1) nf++;
                if (trig_q.size() > 0) chk("tput_word", t_sum, trig_q[0] - 15);
                if (t_last === 1'b1) begin
                    chk("tput_group_len", cnt, 16);
                    chk("tput_first_count", nf, 1);
                    if (trig_q.size() > 0) void'(trig_q.pop_front());
                    cnt = 0; nf = 0; groups++;
                end
            end
            if (acc) begin
                acc_n++;
                if (acc_n >= 2 && acc_n <= 31) chk("tput_fill_gap", cyc - last_acc, 1);
                if (acc_n > 31) chk("tput_gap", cyc - last_acc, 17);
                if (acc_n >= 31) trig_q.push_back(int'(t_data));
                last_acc = cyc;
            end
            @(posedge clock); #1;
            if (acc) t_data = t_data + 16'sd1;
        end
        t_stb = 1'b0;
        chk("tput_groups", groups, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish by 500000");
        $fatal(1);
    end

endmodule
`default_nettype wire
